i2c_arbiter: RTL and testbench

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_pkg.sv | 13 +
 rtl/rr_pick.sv | 29 ++
 rtl/i2c_arbiter.sv | 142 ++++++++++++++
 tb/tb_i2c_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths and arbiter state encodings, also
// used by the I2C controller and the sensor clients.
package i2c_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWNED = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority selector: returns a one-hot grant for the first
// requester found searching upward from the client after 'last'.
module rr_pick #(
  parameter int N  = 2,
  parameter int LW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [LW-1:0] idx;

  // Walk the clients in rotated order and keep only the first one requesting
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = LW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Multi-client arbiter in front of a single I2C controller. One client owns
// the controller at a time; ownership is held across a whole transaction and
// can be revoked only by the strobe-count timeout or reset.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [N-1:0]        c_req,
  output logic [N-1:0]        c_gnt,
  output logic [N-1:0]        c_strobe,
  input  logic [N-1:0]        c_enable,
  input  logic [N-1:0]        c_reg_rdwr,
  input  logic [N*ADDR_W-1:0] c_reg_addr,
  input  logic [N*DATA_W-1:0] c_reg_wrdata,
  input  logic [N*LEN_W-1:0]  c_reg_len,
  output logic [N-1:0]        c_done,
  output logic [N-1:0]        c_rd_done,
  output logic [N-1:0]        c_ack,
  output logic [DATA_W-1:0]   c_rddata,
  input  logic                i2c_strobe,
  input  logic                i2c_done,
  input  logic                i2c_rd_done,
  input  logic                i2c_ack,
  input  logic [DATA_W-1:0]   i2c_reg_rddata,
  output logic                i2c_enable,
  output logic                i2c_reg_rdwr,
  output logic [ADDR_W-1:0]   i2c_reg_addr,
  output logic [DATA_W-1:0]   i2c_reg_wrdata,
  output logic [LEN_W-1:0]    i2c_reg_len,
  output logic                timeout_err,
  output logic                busy
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    state;
  logic [LW-1:0] last_owner;
  logic [LW-1:0] owner_idx;
  logic [CW-1:0] cnt;
  logic [N-1:0]  pick;

  rr_pick #(.N(N), .LW(LW)) u_pick (
    .req  (c_req),
    .last (last_owner),
    .gnt  (pick)
  );

  // Decode the one-hot grant into an index for per-owner bit selects
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (c_gnt[i]) owner_idx = LW'(i);
    end
  end

  // Ownership state machine with strobe-counted timeout on stuck transactions
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      c_gnt       <= '0;
      last_owner  <= LW'(N - 1);
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|c_req) begin
            c_gnt <= pick;
            state <= S_OWNED;
          end
        end
        S_OWNED: begin
          if (c_enable[owner_idx] && i2c_strobe) begin
            state <= S_BUSY;
            cnt   <= '0;
          end else if (!c_req[owner_idx]) begin
            state      <= S_IDLE;
            c_gnt      <= '0;
            last_owner <= owner_idx;
          end
        end
        S_BUSY: begin
          if (i2c_strobe) begin
            if (i2c_done) begin
              if (c_req[owner_idx]) begin
                state <= S_OWNED;
              end else begin
                state      <= S_IDLE;
                c_gnt      <= '0;
                last_owner <= owner_idx;
              end
            end else if (cnt == CW'(TIMEOUT - 1)) begin
              state       <= S_IDLE;
              c_gnt       <= '0;
              last_owner  <= owner_idx;
              timeout_err <= 1'b1;
              cnt         <= cnt + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          c_gnt <= '0;
        end
      endcase
    end
  end

  // Forward only the owner's request fields; everything reads zero with no owner
  always_comb begin
    i2c_enable     = 1'b0;
    i2c_reg_rdwr   = 1'b0;
    i2c_reg_addr   = '0;
    i2c_reg_wrdata = '0;
    i2c_reg_len    = '0;
    for (int i = 0; i < N; i++) begin
      if (c_gnt[i]) begin
        i2c_enable     = c_enable[i];
        i2c_reg_rdwr   = c_reg_rdwr[i];
        i2c_reg_addr   = c_reg_addr[ADDR_W*i +: ADDR_W];
        i2c_reg_wrdata = c_reg_wrdata[DATA_W*i +: DATA_W];
        i2c_reg_len    = c_reg_len[LEN_W*i +: LEN_W];
      end
    end
  end

  assign c_strobe  = c_gnt & {N{i2c_strobe}};
  assign c_done    = c_gnt & {N{i2c_done}};
  assign c_rd_done = c_gnt & {N{i2c_rd_done}};
  assign c_ack     = c_gnt & {N{i2c_ack}};
  assign c_rddata  = i2c_reg_rddata;
  assign busy      = (state == S_BUSY);

endmodule

// File: tb/tb_i2c_arbiter.sv
// Table-driven bench for i2c_arbiter (N=2, TIMEOUT=8) with an expectation queue.
module tb_i2c_arbiter;

  logic        clk;
  logic        rstn;
  logic [1:0]  c_req, c_gnt, c_strobe, c_enable, c_reg_rdwr;
  logic [15:0] c_reg_addr, c_reg_wrdata;
  logic [9:0]  c_reg_len;
  logic [1:0]  c_done, c_rd_done, c_ack;
  logic [7:0]  c_rddata;
  logic        i2c_strobe, i2c_done, i2c_rd_done, i2c_ack;
  logic [7:0]  i2c_reg_rddata;
  logic        i2c_enable, i2c_reg_rdwr;
  logic [7:0]  i2c_reg_addr, i2c_reg_wrdata;
  logic [4:0]  i2c_reg_len;
  logic        timeout_err, busy;

  typedef struct {
    string      name;
    logic       rstn;
    logic [1:0] req;
    logic [1:0] en;
    logic [1:0] rdwr;
    logic       strobe;
    logic       done;
    logic       rd_done;
    logic       ack;
    logic [1:0] gnt;
    logic       busy;
    logic       terr;
    logic       ien;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[14];
  int   compared = 0;
  int   failed   = 0;
  int   rd_pulses0 = 0;
  int   rd_pulses1 = 0;

  i2c_arbiter #(.N(2), .TIMEOUT(8)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .c_req          (c_req),
    .c_gnt          (c_gnt),
    .c_strobe       (c_strobe),
    .c_enable       (c_enable),
    .c_reg_rdwr     (c_reg_rdwr),
    .c_reg_addr     (c_reg_addr),
    .c_reg_wrdata   (c_reg_wrdata),
    .c_reg_len      (c_reg_len),
    .c_done         (c_done),
    .c_rd_done      (c_rd_done),
    .c_ack          (c_ack),
    .c_rddata       (c_rddata),
    .i2c_strobe     (i2c_strobe),
    .i2c_done       (i2c_done),
    .i2c_rd_done    (i2c_rd_done),
    .i2c_ack        (i2c_ack),
    .i2c_reg_rddata (i2c_reg_rddata),
    .i2c_enable     (i2c_enable),
    .i2c_reg_rdwr   (i2c_reg_rdwr),
    .i2c_reg_addr   (i2c_reg_addr),
    .i2c_reg_wrdata (i2c_reg_wrdata),
    .i2c_reg_len    (i2c_reg_len),
    .timeout_err    (timeout_err),
    .busy           (busy)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input string nm, input logic r, input logic [1:0] rq,
                              input logic [1:0] en, input logic [1:0] rw,
                              input logic st, input logic dn, input logic rd,
                              input logic ak, input logic [1:0] g, input logic b,
                              input logic te, input logic ie);
    vec_t v;
    v.name = nm; v.rstn = r; v.req = rq; v.en = en; v.rdwr = rw;
    v.strobe = st; v.done = dn; v.rd_done = rd; v.ack = ak;
    v.gnt = g; v.busy = b; v.terr = te; v.ien = ie;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    logic [7:0] ea, ew;
    logic [4:0] el;
    e  = sb_q.pop_front();
    ea = (e.gnt == 2'b01) ? 8'hF4 : (e.gnt == 2'b10) ? 8'h88 : 8'h00;
    ew = (e.gnt == 2'b01) ? 8'h4B : (e.gnt == 2'b10) ? 8'h5A : 8'h00;
    el = (e.gnt == 2'b01) ? 5'd3  : (e.gnt == 2'b10) ? 5'd17 : 5'd0;
    cmp({e.name, "/gnt"},     32'(c_gnt),          32'(e.gnt));
    cmp({e.name, "/busy"},    32'(busy),           32'(e.busy));
    cmp({e.name, "/terr"},    32'(timeout_err),    32'(e.terr));
    cmp({e.name, "/ien"},     32'(i2c_enable),     32'(e.ien));
    cmp({e.name, "/addr"},    32'(i2c_reg_addr),   32'(ea));
    cmp({e.name, "/wrdata"},  32'(i2c_reg_wrdata), 32'(ew));
    cmp({e.name, "/len"},     32'(i2c_reg_len),    32'(el));
    cmp({e.name, "/rdwr"},    32'(i2c_reg_rdwr),   32'(|(e.gnt & e.rdwr)));
    cmp({e.name, "/strobe"},  32'(c_strobe),       32'(e.gnt & {2{e.strobe}}));
    cmp({e.name, "/done"},    32'(c_done),         32'(e.gnt & {2{e.done}}));
    cmp({e.name, "/rd_done"}, 32'(c_rd_done),      32'(e.gnt & {2{e.rd_done}}));
    cmp({e.name, "/ack"},     32'(c_ack),          32'(e.gnt & {2{e.ack}}));
    cmp({e.name, "/rddata"},  32'(c_rddata),       32'h0000_00A7);
    if (c_rd_done[0]) rd_pulses0++;
    if (c_rd_done[1]) rd_pulses1++;
  endtask

  task automatic applyStimulus(input vec_t v);
    rstn        = v.rstn;
    c_req       = v.req;
    c_enable    = v.en;
    c_reg_rdwr  = v.rdwr;
    i2c_strobe  = v.strobe;
    i2c_done    = v.done;
    i2c_rd_done = v.rd_done;
    i2c_ack     = v.ack;
    sb_q.push_back(v);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; c_req = '0; c_enable = '0; c_reg_rdwr = '0;
    c_reg_addr = {8'h88, 8'hF4};
    c_reg_wrdata = {8'h5A, 8'h4B};
    c_reg_len = {5'd17, 5'd3};
    i2c_strobe = 1'b0; i2c_done = 1'b0; i2c_rd_done = 1'b0; i2c_ack = 1'b0;
    i2c_reg_rddata = 8'hA7;
    repeat (2) @(posedge clk);
    #1;

    tbl[0]  = mk("reset",            0, 2'b11, 2'b11, 2'b00, 1, 0, 0, 0, 2'b00, 0, 0, 0);
    tbl[1]  = mk("idle_req",         1, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    tbl[2]  = mk("grant0",           1, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0);
    tbl[3]  = mk("en_nostrobe",      1, 2'b11, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 1);
    tbl[4]  = mk("write_start",      1, 2'b11, 2'b01, 2'b00, 1, 0, 0, 0, 2'b01, 0, 0, 1);
    tbl[5]  = mk("busy_nonowner_en", 1, 2'b11, 2'b10, 2'b00, 1, 0, 0, 0, 2'b01, 1, 0, 0);
    tbl[6]  = mk("write_done",       1, 2'b11, 2'b00, 2'b00, 1, 1, 0, 1, 2'b01, 1, 0, 0);
    tbl[7]  = mk("owned_again",      1, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0);
    tbl[8]  = mk("release0",         1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0);
    tbl[9]  = mk("idle_after0",      1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    tbl[10] = mk("grant1",           1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 2'b10, 0, 0, 0);
    tbl[11] = mk("nonowner_en0",     1, 2'b10, 2'b01, 2'b00, 1, 0, 0, 0, 2'b10, 0, 0, 0);
    tbl[12] = mk("release1",         1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b10, 0, 0, 0);
    tbl[13] = mk("idle_end",         1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0);

    $display("[TB] table vectors");
    for (int i = 0; i < 14; i++) applyStimulus(tbl[i]);

    $display("[TB] read with request dropped mid-transaction");
    rd_pulses0 = 0;
    rd_pulses1 = 0;
    applyStimulus(mk("rd_idle",  1, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    applyStimulus(mk("rd_grant", 1, 2'b01, 2'b01, 2'b01, 1, 0, 0, 0, 2'b01, 0, 0, 1));
    for (int i = 0; i < 3; i++)
      applyStimulus(mk("rd_byte", 1, 2'b00, 2'b00, 2'b01, 1, 0, 1, 1, 2'b01, 1, 0, 0));
    applyStimulus(mk("rd_gap",      1, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 2'b01, 1, 0, 0));
    applyStimulus(mk("rd_done",     1, 2'b00, 2'b00, 2'b01, 1, 1, 0, 0, 2'b01, 1, 0, 0));
    applyStimulus(mk("rd_released", 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    cmp("rd_pulses_owner",    32'(rd_pulses0), 32'd3);
    cmp("rd_pulses_nonowner", 32'(rd_pulses1), 32'd0);

    $display("[TB] timeout after 8 strobes");
    applyStimulus(mk("to_idle",  1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    applyStimulus(mk("to_start", 1, 2'b10, 2'b10, 2'b00, 1, 0, 0, 0, 2'b10, 0, 0, 1));
    for (int k = 1; k <= 8; k++) begin
      if (k == 5)
        applyStimulus(mk("to_gap", 1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 2'b10, 1, 0, 0));
      applyStimulus(mk("to_strobe", 1, 2'b10, 2'b00, 2'b00, 1, 0, 0, 0, 2'b10, 1, 0, 0));
    end
    applyStimulus(mk("to_expired",   1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 0));
    applyStimulus(mk("to_pulse_end", 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0));

    $display("[TB] reset while busy");
    applyStimulus(mk("rst_idle0",   1, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    applyStimulus(mk("rst_own0",    1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0));
    applyStimulus(mk("rst_idle1",   1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    applyStimulus(mk("rst_start1",  1, 2'b10, 2'b10, 2'b00, 1, 0, 0, 0, 2'b10, 0, 0, 1));
    applyStimulus(mk("rst_assert",  0, 2'b11, 2'b00, 2'b00, 1, 0, 0, 0, 2'b10, 1, 0, 0));
    applyStimulus(mk("rst_after",   1, 2'b11, 2'b11, 2'b00, 1, 0, 0, 0, 2'b00, 0, 0, 0));
    applyStimulus(mk("rst_regrant", 1, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0));
    applyStimulus(mk("rst_rel",     1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 0));
    applyStimulus(mk("rst_end",     1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
